alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
ID/EX stage that sits directly upstream of the 32-bit ALU. It registers one decoded RV32I instruction, derives the 4-bit ALU operation code, and selects operand B from rs2 or the immediate. It forwards results from EX/MEM and MEM/WB onto operands A/B. A valid/ready handshake supports stall and flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
FWD_EN, 1, 1 = forwarding enabled; 0 = operands pass through from the register file unmodified.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
in_valid  input  1  decode stage presents an instruction
in_ready  output  1  stage can accept this cycle
opcode  input  7  instr[6:0]
funct3  input  3  instr[14:12]
funct7  input  7  instr[31:25]
rs1_addr, rs2_addr, rd_addr  input  5 each  register indices
rs1_data, rs2_data  input  32 each  register-file read data
imm  input  32  sign-extended immediate
pc  input  32  instruction address
flush  input  1  kill the held instruction
exmem_wr_en  input  1  EX/MEM will write rd
exmem_rd  input  5  EX/MEM destination
exmem_result  input  32  EX/MEM value
memwb_wr_en  input  1  MEM/WB will write rd
memwb_rd  input  5  MEM/WB destination
memwb_data  input  32  MEM/WB value
out_valid  output  1  A/B/ALU_control are valid
out_ready  input  1  EX consumes this cycle
A  output  32  ALU operand A
B  output  32  ALU operand B
ALU_control  output  4  ALU operation code
rd_out  output  5  registered rd
illegal  output  1  registered: opcode unsupported

Behaviour:
- Reset: out_valid=0, illegal=0, ALU_control=4'b0000. All held fields (operands, rd, pc, imm, selects) are 0. A=B=0.
- in_ready = !out_valid || out_ready (combinational). A transfer happens when in_valid && in_ready.
- Capture on transfer at the rising edge: out_valid=1 next cycle. Latency is one cycle.
- out_valid && !out_ready: hold every registered field. in_ready=0.
- Consume without a new transfer: out_valid=0 next cycle.
- flush=1: out_valid=0 next edge. Flush wins over a simultaneous capture; the incoming instruction is dropped. in_ready is not affected by flush.
- RESET mid-stall: returns all state to reset values asynchronously.
- ALU_control encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLTU, 1001 SLT.
- OP (0110011) and OP-IMM (0010011) decode by funct3:
  - 000: ADD; SUB only when OP and funct7[5]=1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1 (both OP and OP-IMM).
  - 110: OR. 111: AND.
- BRANCH (1100011) decodes by funct3:
  - 000/001: SUB.
  - 100/101: SLT.
  - 110/111: SLTU.
- LOAD (0000011), STORE (0100011), JALR (1100111): ADD, B=imm.
- LUI (0110111): ADD, A=0, B=imm. AUIPC (0010111): ADD, A=pc, B=imm.
- Any other opcode: ADD, A=B=0, illegal=1 (registered with the instruction).
- B source: OP and BRANCH use rs2 (forwarded). All other opcodes use imm.
- Forwarding is combinational on the registered rs indices and evaluated every cycle, including stalls:
  - Use the EX/MEM value if exmem_wr_en && exmem_rd==rs && rs!=0.
  - Else use the MEM/WB value if memwb_wr_en && memwb_rd==rs && rs!=0.
  - Else use the registered rf data.
  - EX/MEM has priority. Register x0 always reads 0.
- A uses forwarded rs1 except for LUI/AUIPC.
- When out_valid=0, outputs keep their last values (don't-care to EX).

Test Plan:
- Reset then idle: out_valid=0, ALU_control=0000, A=B=0, in_ready=1.
- OP funct3=000 funct7=0100000, rs1_data=10, rs2_data=3 -> next cycle out_valid=1, ALU_control=0001, A=10, B=3. OP-IMM funct3=101 funct7=0100000, imm=4 -> ALU_control=0111, B=4.
- Held rs1=5; exmem_wr_en=1, exmem_rd=5, exmem_result=0xAA; memwb_rd=5, memwb_data=0xBB -> A=0xAA. Drop exmem_wr_en -> A=0xBB. rs1=0 with exmem_rd=0 -> A=0.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and fields held. out_ready=1 -> next instruction captured on that edge.
- flush=1 together with a valid transfer -> out_valid=0 next cycle. Opcode 1111111 -> illegal=1, ALU_control=0000, A=B=0.
- BRANCH funct3=110 -> ALU_control=1000. LUI imm=0x12345000 -> A=0, B=0x12345000. AUIPC pc=0x100 -> A=0x100.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers one decoded RV32I instruction, derives the ALU
// operation code, and presents forwarded operands A/B with a valid/ready handshake.
module alu_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            exmem_wr_en,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_wr_en,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALU_control,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1001;

  // SRC_ALT means pc for operand A and imm for operand B
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_REG  = 2'd1,
    SRC_ALT  = 2'd2
  } src_e;

  logic [ALU_W-1:0] alu_d;
  src_e             a_sel_d, b_sel_d, a_sel_q, b_sel_q;
  logic             illegal_d;
  logic [REG_W-1:0] rs1_addr_q, rs2_addr_q;
  logic [XLEN-1:0]  rs1_data_q, rs2_data_q, imm_q, pc_q;
  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  logic             unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign in_ready      = !out_valid || out_ready;

  // Decode of the incoming instruction into ALU op and operand selects
  always_comb begin
    alu_d     = ALU_ADD;
    a_sel_d   = SRC_ZERO;
    b_sel_d   = SRC_ZERO;
    illegal_d = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        a_sel_d = SRC_REG;
        b_sel_d = (opcode == OPC_OP) ? SRC_REG : SRC_ALT;
        case (funct3)
          3'b000:  alu_d = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_d = ALU_SLL;
          3'b010:  alu_d = ALU_SLT;
          3'b011:  alu_d = ALU_SLTU;
          3'b100:  alu_d = ALU_XOR;
          3'b101:  alu_d = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_d = ALU_OR;
          default: alu_d = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        a_sel_d = SRC_REG;
        b_sel_d = SRC_REG;
        case (funct3)
          3'b000, 3'b001: alu_d = ALU_SUB;
          3'b100, 3'b101: alu_d = ALU_SLT;
          3'b110, 3'b111: alu_d = ALU_SLTU;
          default:        alu_d = ALU_ADD;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        a_sel_d = SRC_REG;
        b_sel_d = SRC_ALT;
      end
      OPC_LUI: begin
        a_sel_d = SRC_ZERO;
        b_sel_d = SRC_ALT;
      end
      OPC_AUIPC: begin
        a_sel_d = SRC_ALT;
        b_sel_d = SRC_ALT;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Flush beats capture; a consume with no new transfer empties the stage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid   <= 1'b0;
      ALU_control <= ALU_ADD;
      rd_out      <= '0;
      illegal     <= 1'b0;
      a_sel_q     <= SRC_ZERO;
      b_sel_q     <= SRC_ZERO;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      ALU_control <= alu_d;
      rd_out      <= rd_addr;
      illegal     <= illegal_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      rs1_addr_q  <= rs1_addr;
      rs2_addr_q  <= rs2_addr;
      rs1_data_q  <= rs1_data;
      rs2_data_q  <= rs2_data;
      imm_q       <= imm;
      pc_q        <= pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_W-1:0] addr,
    input logic [XLEN-1:0]  rf,
    input logic             ex_en,
    input logic [REG_W-1:0] ex_rd,
    input logic [XLEN-1:0]  ex_val,
    input logic             wb_en,
    input logic [REG_W-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_val
  );
    if (addr == '0)                    return '0;
    else if (ex_en && ex_rd == addr)   return ex_val;
    else if (wb_en && wb_rd == addr)   return wb_val;
    else                               return rf;
  endfunction

  // Forwarding tracks the live EX/MEM and MEM/WB buses, including during stalls
  always_comb begin
    rs1_fwd = rs1_data_q;
    rs2_fwd = rs2_data_q;
    if (FWD_EN) begin
      rs1_fwd = fwd(rs1_addr_q, rs1_data_q, exmem_wr_en, exmem_rd, exmem_result,
                    memwb_wr_en, memwb_rd, memwb_data);
      rs2_fwd = fwd(rs2_addr_q, rs2_data_q, exmem_wr_en, exmem_rd, exmem_result,
                    memwb_wr_en, memwb_rd, memwb_data);
    end
  end

  always_comb begin
    A = '0;
    case (a_sel_q)
      SRC_REG: A = rs1_fwd;
      SRC_ALT: A = pc_q;
      default: A = '0;
    endcase
  end

  always_comb begin
    B = '0;
    case (b_sel_q)
      SRC_REG: B = rs2_fwd;
      SRC_ALT: B = imm_q;
      default: B = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected results queued at drive time,
// popped and compared when the stage presents them.
`timescale 1ns/1ps
module tb_alu_operand_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid, in_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        flush;
  logic        exmem_wr_en, memwb_wr_en;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic        out_valid, out_ready;
  logic [31:0] A, B;
  logic [3:0]  ALU_control;
  logic [4:0]  rd_out;
  logic        illegal;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc;
  } instr_t;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .flush(flush),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALU_control(ALU_control), .rd_out(rd_out), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im,
                                input logic [31:0] p);
    instr_t t;
    t.op = op; t.f3 = f3; t.f7 = f7; t.imm = im; t.pc = p;
    t.rs1 = 5'd1; t.rs2 = 5'd2;
    t.rd  = 5'($urandom_range(31, 1));
    t.d1  = $urandom; t.d2 = $urandom;
    return t;
  endfunction

  // Reference decode written from the opcode/funct tables (forwarding idle)
  function automatic exp_t model(input instr_t t);
    exp_t e;
    e.rd = t.rd; e.ill = 1'b0; e.alu = 4'h0; e.a = t.d1; e.b = t.imm;
    case (t.op)
      7'b0110011, 7'b0010011: begin
        if (t.op == 7'b0110011) e.b = t.d2;
        case (t.f3)
          3'd0: e.alu = (t.op == 7'b0110011 && t.f7 == 7'b0100000) ? 4'h1 : 4'h0;
          3'd1: e.alu = 4'h5;
          3'd2: e.alu = 4'h9;
          3'd3: e.alu = 4'h8;
          3'd4: e.alu = 4'h4;
          3'd5: e.alu = (t.f7 == 7'b0100000) ? 4'h7 : 4'h6;
          3'd6: e.alu = 4'h3;
          default: e.alu = 4'h2;
        endcase
      end
      7'b1100011: begin
        e.b = t.d2;
        if (t.f3 == 3'd0 || t.f3 == 3'd1) e.alu = 4'h1;
        else if (t.f3 == 3'd4 || t.f3 == 3'd5) e.alu = 4'h9;
        else if (t.f3 == 3'd6 || t.f3 == 3'd7) e.alu = 4'h8;
      end
      7'b0000011, 7'b0100011, 7'b1100111: ;
      7'b0110111: e.a = 32'h0;
      7'b0010111: e.a = t.pc;
      default: begin e.a = 32'h0; e.b = 32'h0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic apply(input instr_t t);
    opcode = t.op; funct3 = t.f3; funct7 = t.f7;
    rs1_addr = t.rs1; rs2_addr = t.rs2; rd_addr = t.rd;
    rs1_data = t.d1; rs2_data = t.d2; imm = t.imm; pc = t.pc;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
    exmem_wr_en = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_wr_en = 1'b0; memwb_rd = '0; memwb_data = '0;
    repeat (2) @(negedge CLK);
    n_cmp++; if ({out_valid, illegal, ALU_control, rd_out} !== 11'h0) begin
      n_bad++; $display("FAIL reset_ctrl: got v=%b ill=%b alu=%h rd=%0d, want all 0",
                        out_valid, illegal, ALU_control, rd_out); end
    n_cmp++; if ({A, B} !== 64'h0) begin
      n_bad++; $display("FAIL reset_ops: got A=%h B=%h, want 0/0", A, B); end
    n_cmp++; if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
    RESET = 1'b0;
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0 || A !== 32'h0) begin
      n_bad++; $display("FAIL idle: got v=%b A=%h, want v=0 A=0", out_valid, A); end
  endtask

  task automatic test_back_to_back();
    instr_t tbl[$];
    exp_t   e;
    tbl.push_back(mk(7'b0110011, 3'd0, 7'b0100000, 32'h0, 32'h0));       // SUB
    tbl[0].d1 = 32'd10; tbl[0].d2 = 32'd3;
    tbl.push_back(mk(7'b0010011, 3'd5, 7'b0100000, 32'd4, 32'h0));       // SRAI
    tbl.push_back(mk(7'b0010011, 3'd0, 7'b0100000, 32'hFFFF_FFF0, 32'h0)); // ADDI, f7[5] ignored
    tbl.push_back(mk(7'b0110011, 3'd0, 7'b0000000, 32'h0, 32'h0));       // ADD
    tbl.push_back(mk(7'b0110011, 3'd1, 7'b0000000, 32'h0, 32'h0));
    tbl.push_back(mk(7'b0110011, 3'd2, 7'b0000000, 32'h0, 32'h0));
    tbl.push_back(mk(7'b0110011, 3'd3, 7'b0000000, 32'h0, 32'h0));
    tbl.push_back(mk(7'b0110011, 3'd4, 7'b0000000, 32'h0, 32'h0));
    tbl.push_back(mk(7'b0110011, 3'd5, 7'b0000000, 32'h0, 32'h0));
    tbl.push_back(mk(7'b0110011, 3'd5, 7'b0100000, 32'h0, 32'h0));
    tbl.push_back(mk(7'b0010011, 3'd6, 7'b0000000, 32'h77, 32'h0));
    tbl.push_back(mk(7'b0010011, 3'd7, 7'b0000000, 32'h0F, 32'h0));
    tbl.push_back(mk(7'b1100011, 3'd1, 7'b0000000, 32'h40, 32'h0));
    tbl.push_back(mk(7'b1100011, 3'd4, 7'b0000000, 32'h40, 32'h0));
    tbl.push_back(mk(7'b1100011, 3'd6, 7'b0000000, 32'h40, 32'h0));
    tbl.push_back(mk(7'b0000011, 3'd2, 7'b0000000, 32'h8, 32'h0));
    tbl.push_back(mk(7'b0100011, 3'd2, 7'b0000000, 32'hC, 32'h0));
    tbl.push_back(mk(7'b1100111, 3'd0, 7'b0000000, 32'h10, 32'h0));
    tbl.push_back(mk(7'b0110111, 3'd0, 7'b0000000, 32'h1234_5000, 32'h200));
    tbl.push_back(mk(7'b0010111, 3'd0, 7'b0000000, 32'h0000_1000, 32'h100));
    tbl.push_back(mk(7'b1111111, 3'd0, 7'b0100000, 32'hDEAD_BEEF, 32'h300));
    tbl.push_back(mk(7'b0110011, 3'd7, 7'b0000000, 32'h0, 32'h0));
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      q.push_back(model(tbl[i]));
      @(negedge CLK);
      e = q.pop_front();
      n_cmp++; if (out_valid !== 1'b1) begin
        n_bad++; $display("FAIL b2b_valid[%0d]: got %b, want 1", i, out_valid); end
      n_cmp++; if ({ALU_control, A, B, rd_out, illegal} !== e) begin
        n_bad++; $display("FAIL b2b_out[%0d]: got alu=%h A=%h B=%h rd=%0d ill=%b, want alu=%h A=%h B=%h rd=%0d ill=%b",
                          i, ALU_control, A, B, rd_out, illegal, e.alu, e.a, e.b, e.rd, e.ill); end
    end
    in_valid = 1'b0;
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drain: got v=%b, want 0", out_valid); end
  endtask

  task automatic test_forwarding();
    instr_t t;
    t = mk(7'b0110011, 3'd0, 7'b0000000, 32'h0, 32'h0);
    t.rs1 = 5'd5; t.rs2 = 5'd6; t.d1 = 32'h11; t.d2 = 32'h22;
    out_ready = 1'b0;
    apply(t);
    @(negedge CLK);
    in_valid = 1'b0;
    exmem_wr_en = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
    memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBB;
    #1;
    n_cmp++; if (A !== 32'hAA || B !== 32'h22) begin
      n_bad++; $display("FAIL fwd_exmem: got A=%h B=%h, want AA/22", A, B); end
    exmem_wr_en = 1'b0; #1;
    n_cmp++; if (A !== 32'hBB) begin
      n_bad++; $display("FAIL fwd_memwb: got A=%h, want BB", A); end
    memwb_rd = 5'd6; #1;
    n_cmp++; if (A !== 32'h11 || B !== 32'hBB) begin
      n_bad++; $display("FAIL fwd_rs2: got A=%h B=%h, want 11/BB", A, B); end
    memwb_wr_en = 1'b0;
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b1 || A !== 32'h11 || B !== 32'h22) begin
      n_bad++; $display("FAIL fwd_hold: got v=%b A=%h B=%h, want 1/11/22", out_valid, A, B); end
    // x0 never forwards even when EX/MEM claims to write it
    t.rs1 = 5'd0; t.d1 = 32'h55;
    exmem_wr_en = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hCC;
    out_ready = 1'b1;
    apply(t);
    @(negedge CLK);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || A !== 32'h0 || B !== 32'h22) begin
      n_bad++; $display("FAIL fwd_x0: got v=%b A=%h B=%h, want 1/0/22", out_valid, A, B); end
    exmem_wr_en = 1'b0; exmem_rd = '0;
    @(negedge CLK);
  endtask

  task automatic test_stall();
    instr_t x, y;
    exp_t   e;
    x = mk(7'b0110011, 3'd4, 7'b0000000, 32'h0, 32'h0);
    y = mk(7'b0010011, 3'd1, 7'b0000000, 32'h3, 32'h0);
    out_ready = 1'b1;
    apply(x);
    q.push_back(model(x));
    @(negedge CLK);
    out_ready = 1'b0;
    apply(y);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall_hs[%0d]: got ready=%b v=%b, want 0/1", c, in_ready, out_valid); end
      n_cmp++; if ({ALU_control, A, B, rd_out, illegal} !== q[0]) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got alu=%h A=%h B=%h rd=%0d, want alu=%h A=%h B=%h rd=%0d",
                          c, ALU_control, A, B, rd_out, q[0].alu, q[0].a, q[0].b, q[0].rd); end
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release: got in_ready=%b, want 1", in_ready); end
    void'(q.pop_front());
    q.push_back(model(y));
    @(negedge CLK);
    in_valid = 1'b0;
    e = q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || {ALU_control, A, B, rd_out, illegal} !== e) begin
      n_bad++; $display("FAIL stall_next: got v=%b alu=%h A=%h B=%h, want v=1 alu=%h A=%h B=%h",
                        out_valid, ALU_control, A, B, e.alu, e.a, e.b); end
    @(negedge CLK);
  endtask

  task automatic test_flush();
    instr_t x, y;
    exp_t   e;
    x = mk(7'b1100011, 3'd6, 7'b0000000, 32'h80, 32'h0);
    y = mk(7'b0110011, 3'd0, 7'b0100000, 32'h0, 32'h0);
    out_ready = 1'b1;
    apply(x);
    q.push_back(model(x));
    @(negedge CLK);
    e = q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || ALU_control !== 4'b1000 || {ALU_control, A, B, rd_out, illegal} !== e) begin
      n_bad++; $display("FAIL flush_pre: got v=%b alu=%h A=%h B=%h, want v=1 alu=%h A=%h B=%h",
                        out_valid, ALU_control, A, B, e.alu, e.a, e.b); end
    apply(y);
    flush = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_ready: got in_ready=%b, want 1", in_ready); end
    @(negedge CLK);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_valid: got v=%b, want 0", out_valid); end
    n_cmp++; if ({ALU_control, A, B, rd_out, illegal} !== e) begin
      n_bad++; $display("FAIL flush_drop: got alu=%h A=%h B=%h rd=%0d, want alu=%h A=%h B=%h rd=%0d",
                        ALU_control, A, B, rd_out, e.alu, e.a, e.b, e.rd); end
  endtask

  task automatic test_reset_mid_stall();
    instr_t x;
    x = mk(7'b0110011, 3'd0, 7'b0100000, 32'h0, 32'h0);
    out_ready = 1'b0;
    apply(x);
    @(negedge CLK);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || ALU_control !== 4'b0001) begin
      n_bad++; $display("FAIL rst_mid_pre: got v=%b alu=%h, want 1/1", out_valid, ALU_control); end
    #2 RESET = 1'b1;
    #1;
    n_cmp++; if ({out_valid, illegal, ALU_control, rd_out} !== 11'h0 || {A, B} !== 64'h0) begin
      n_bad++; $display("FAIL rst_mid: got v=%b alu=%h rd=%0d A=%h B=%h, want all 0",
                        out_valid, ALU_control, rd_out, A, B); end
    @(negedge CLK);
    RESET = 1'b0; out_ready = 1'b1;
    @(negedge CLK);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_after: got ready=%b v=%b, want 1/0", in_ready, out_valid); end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_forwarding();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
